// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: scanned two-sample key debouncer with press/release/long-press event FIFO (long press built only with KEY_SCAN_LONG_EN)
module key_scan_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int SCAN_DIV = 1000000,
  parameter int LONG_TICKS = 50,
  parameter int FIFO_DEPTH = 4,
  localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KW-1:0]       ev_key,
  output logic [1:0]          ev_type,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                overflow,
  input  logic                clr_ovf
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic [KW-1:0] idx, idx_nx;
  logic [NUM_KEYS-1:0] s1, sk, snap, prev;
  logic [CW-1:0] cnt;
  logic tick, p, q, chg, lng, push, pop, full, wr, drop;
  logic [1:0] push_type;
  logic [KW+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      sk <= '1;
      snap <= '1;
      prev <= '1;
      cnt <= '0;
    end else begin
      s1 <= key_in;
      sk <= s1;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        prev <= snap;
        snap <= sk;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (tick ? SCAN : IDLE) : (idx == KW'(NUM_KEYS - 1) ? IDLE : SCAN);
    idx_nx = (state == SCAN && idx != KW'(NUM_KEYS - 1)) ? idx + 1'b1 : '0;
  end
  assign p = ~snap[idx];
  assign q = ~prev[idx];
  assign chg = state == SCAN && p == q && p != key_state[idx];
`ifdef KEY_SCAN_LONG_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hold [NUM_KEYS];
  logic inc;
  assign inc = state == SCAN && !chg && key_state[idx] && hold[idx] < HW'(LONG_TICKS);
  assign lng = inc && hold[idx] + 1'b1 == HW'(LONG_TICKS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold <= '{default: '0};
    else if (chg) hold[idx] <= '0;
    else if (inc) hold[idx] <= hold[idx] + 1'b1;
  end
`else
  assign lng = LONG_TICKS < 0;
`endif
  assign push = chg | lng;
  assign push_type = chg ? {~p, p} : 2'b11;
  assign ev_valid = count != '0;
  assign {ev_key, ev_type} = ev_valid ? mem[rp] : '0;
  assign pop = ev_valid & ev_ready;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign wr = push & (~full | pop);
  assign drop = push & full & ~pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
      key_state <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      overflow <= drop | (overflow & ~clr_ovf);
      if (chg) key_state[idx] <= p;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= {idx, push_type};
endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed self-checking bench for key_scan_ctrl
module tb_key_scan_ctrl;
  logic clk = 0, rst_n = 0, ev_ready = 1, clr_ovf = 0, ev_valid, overflow;
  logic [3:0] key_in = '1, key_state;
  logic [1:0] ev_key, ev_type;
  int cyc = 0, rel = 0, b = 0, checks = 0, errors = 0;
  int evq[$], tq[$];
  key_scan_ctrl #(.NUM_KEYS(4), .SCAN_DIV(8), .LONG_TICKS(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key(ev_key), .ev_type(ev_type), .key_state(key_state), .overflow(overflow), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && ev_valid && ev_ready) begin
    evq.push_back({ev_key, ev_type});
    tq.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int ev_at(input int i);
    return i < evq.size() ? evq[i] : -1;
  endfunction
  function automatic int t_at(input int i);
    return i < tq.size() ? tq[i] - b : -1;
  endfunction
  task automatic align;
    while ((cyc - rel) % 8 != 0) @(negedge clk);
    b = cyc;
  endtask
  task automatic run(input int n);
    repeat (n * 8) @(negedge clk);
  endtask
  task automatic clear_q;
    evq.delete();
    tq.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", ev_valid, 0);
    chk("rst_key", ev_key, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_state", key_state, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    rel = cyc;
    run(10);
    chk("idle_events", evq.size(), 0);
    chk("idle_state", key_state, 0);
    chk("idle_ovf", overflow, 0);
    align;
    key_in[2] = 0;
    run(5);
    chk("k2_state_held", key_state, 4'b0100);
    key_in[2] = 1;
    run(3);
    chk("k2_state_rel", key_state, 0);
    chk("k2_press", ev_at(0), 2 * 4 + 1);
    chk("k2_press_t", t_at(0), 19);
`ifdef KEY_SCAN_LONG_EN
    chk("k2_count", evq.size(), 3);
    chk("k2_long", ev_at(1), 2 * 4 + 3);
    chk("k2_long_t", t_at(1), 43);
    chk("k2_release", ev_at(2), 2 * 4 + 2);
    chk("k2_release_t", t_at(2), 59);
`else
    chk("k2_count", evq.size(), 2);
    chk("k2_release", ev_at(1), 2 * 4 + 2);
    chk("k2_release_t", t_at(1), 59);
`endif
    clear_q;
    align;
    repeat (4) @(negedge clk);
    key_in[1] = 0;
    repeat (3) @(negedge clk);
    key_in[1] = 1;
    align;
    run(2);
    chk("glitch_events", evq.size(), 0);
    chk("glitch_state", key_state, 0);
    align;
    key_in = 4'b0110;
    run(3);
    chk("k30_state", key_state, 4'b1001);
    key_in = '1;
    run(3);
    chk("k30_count", evq.size(), 4);
    chk("k30_first", ev_at(0), 0 * 4 + 1);
    chk("k30_first_t", t_at(0), 17);
    chk("k30_second", ev_at(1), 3 * 4 + 1);
    chk("k30_second_t", t_at(1), 20);
    chk("k30_rel0", ev_at(2), 0 * 4 + 2);
    chk("k30_rel3", ev_at(3), 3 * 4 + 2);
    clear_q;
    align;
    ev_ready = 0;
    repeat (2) begin
      key_in = '0;
      run(3);
      key_in = '1;
      run(3);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_head_key", ev_key, 0);
    chk("ovf_head_type", ev_type, 1);
    chk("ovf_state", key_state, 0);
    repeat (3) @(negedge clk);
    chk("ovf_stable_key", ev_key, 0);
    chk("ovf_stable_type", ev_type, 1);
    ev_ready = 1;
    repeat (8) @(negedge clk);
    chk("drain_valid", ev_valid, 0);
    chk("drain_count", evq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_ev%0d", i), ev_at(i), i * 4 + 1);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1;
    @(negedge clk);
    clr_ovf = 0;
    chk("ovf_clr", overflow, 0);
    clear_q;
    align;
    ev_ready = 0;
    key_in = 4'b1100;
    run(2);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", ev_valid, 1);
    chk("pre_rst_state", key_state, 4'b0011);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_state", key_state, 0);
    chk("mid_rst_type", ev_type, 0);
    key_in = '1;
    ev_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rel = cyc;
    run(10);
    chk("post_rst_events", evq.size(), 0);
    chk("post_rst_state", key_state, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
